// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and the in-flight tag type for the miniRV
// RAW-hazard controller.
//   FWD_NONE          forward-select code meaning "read the register file"
//   STG_EXE/MEM/WB    stage indices as seen by the tag pipeline (1 = EXE)
//   tag_t             {v, rd, ld} carried down the tag pipeline
// The tag rd field is TAG_RD_W wide; REG_AW must not exceed it. Narrower
// register addresses are zero-extended into it.
package hazard_pkg;

  localparam int FWD_NONE = 0;
  localparam int STG_EXE  = 1;
  localparam int STG_MEM  = 2;
  localparam int STG_WB   = 3;

  localparam int TAG_RD_W = 8;

  typedef logic [TAG_RD_W-1:0] tag_rd_t;

  typedef struct packed {
    logic    v;
    tag_rd_t rd;
    logic    ld;
  } tag_t;

endpackage

// File: rtl/hazard_tag_pipe.sv
// hazard_tag_pipe: HAZ_DEPTH-entry shift register of destination tags that
// mirrors the EXE..WB pipeline. It never stalls; the caller supplies a
// bubble (v = 0) in tag_in whenever ID does not issue a writer.
//   clk, rst_n   clock, async active-low reset (all entries cleared)
//   tag_in       tag entering stage 1 (EXE) on the next clock
//   tags[k]      tag currently held in stage k, k = 1..HAZ_DEPTH
module hazard_tag_pipe
  import hazard_pkg::*;
#(
  parameter int HAZ_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  tag_t                 tag_in,
  output tag_t [HAZ_DEPTH:1]   tags
);

  tag_t [HAZ_DEPTH:1] tag_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[1] <= tag_in;
      for (int k = 2; k <= HAZ_DEPTH; k++)
        tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  assign tags = tag_pipe;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW-hazard controller for the in-order miniRV pipeline.
// Sits beside ID, tracks in-flight destination tags EXE..WB and drives the
// stall / bubble / flush controls and, optionally, forwarding selects.
//   id_valid/id_rs/id_rs_used/id_rd/id_we/id_is_load   ID instruction
//   br_flush                 taken branch/jump resolved in EXE
//   stall_pc/stall_if_id     hold PC and IF/ID
//   bubble_id_exe            NOP into ID/EXE (stall or flush)
//   flush_if_id              clear IF/ID
//   fwd_sel                  per-port forward source stage (0 = regfile)
//   stall_cnt/flush_cnt      saturating performance counters
// Build option: define FORWARDING_EN for forwarding mode; left undefined the
// block is a full interlock and fwd_sel is tied to 0.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int REG_AW    = 5,
  parameter int HAZ_DEPTH = 3,
  parameter int CNT_W     = 16
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]                  id_rs,
  input  logic [NUM_SRC-1:0]                         id_rs_used,
  input  logic [REG_AW-1:0]                          id_rd,
  input  logic                                       id_we,
  input  logic                                       id_is_load,
  input  logic                                       br_flush,
  output logic                                       stall_pc,
  output logic                                       stall_if_id,
  output logic                                       bubble_id_exe,
  output logic                                       flush_if_id,
  output logic [NUM_SRC*$clog2(HAZ_DEPTH+1)-1:0]     fwd_sel,
  output logic [CNT_W-1:0]                           stall_cnt,
  output logic [CNT_W-1:0]                           flush_cnt
);

  localparam int FSW = $clog2(HAZ_DEPTH+1);

  tag_t [HAZ_DEPTH:1] tags;
  tag_t               tag_in;
  logic [NUM_SRC-1:0] raw_p;
  logic               stall;
  logic               issue;

  // Only real register writers enter the tag pipe; a stalled or squashed
  // ID instruction becomes a bubble.
  assign issue = id_valid && id_we && (id_rd != '0) && !stall && !br_flush;

  always_comb begin
    tag_in = '0;
    if (issue) begin
      tag_in.v  = 1'b1;
      tag_in.rd = tag_rd_t'(id_rd);
      tag_in.ld = id_is_load;
    end
  end

  hazard_tag_pipe #(
    .HAZ_DEPTH (HAZ_DEPTH)
  ) u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .tag_in (tag_in),
    .tags   (tags)
  );

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_port
    tag_rd_t            rs;
    logic [HAZ_DEPTH:1] hit;

    assign rs = tag_rd_t'(id_rs[i*REG_AW +: REG_AW]);

    // x0 is never a hazard and unread ports are ignored.
    always_comb begin
      hit = '0;
      for (int k = 1; k <= HAZ_DEPTH; k++)
        hit[k] = id_rs_used[i] && (rs != '0) && tags[k].v && (tags[k].rd == rs);
    end

`ifdef FORWARDING_EN
    logic [FSW-1:0] near;

    // Youngest writer (smallest stage) wins; scan oldest to youngest so the
    // last hit seen is the nearest one.
    always_comb begin
      near = FSW'(FWD_NONE);
      for (int k = HAZ_DEPTH; k >= 1; k--)
        if (hit[k]) near = FSW'(k);
    end

    // Only a load still in EXE cannot be forwarded; a hit in EXE is always
    // the nearest one, so no priority check is needed here.
    assign raw_p[i]              = hit[STG_EXE] && tags[STG_EXE].ld;
    assign fwd_sel[i*FSW +: FSW] = near;
`else
    assign raw_p[i]              = |hit;
    assign fwd_sel[i*FSW +: FSW] = FSW'(FWD_NONE);
`endif
  end

  // A taken branch squashes the ID instruction, so it overrides any stall.
  assign stall         = id_valid && (|raw_p) && !br_flush;
  assign stall_pc      = stall;
  assign stall_if_id   = stall;
  assign bubble_id_exe = stall || br_flush;
  assign flush_if_id   = br_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // Load flags beyond EXE (and all of them in interlock mode) are carried
  // only for visibility; fold them here so partial use is explicit.
  logic unused_tags;
  assign unused_tags = ^tags;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl. The driver issues one ID
// cycle at a time, predicts the response from a list of issued writers
// (stage = cycles since issue) and queues it; a monitor pops and compares on
// the opposite clock edge. A second instance with CNT_W = 4 shares the
// stimulus to exercise counter saturation.
module tb_hazard_ctrl;

  localparam int NUM_SRC   = 2;
  localparam int REG_AW    = 5;
  localparam int HAZ_DEPTH = 3;
  localparam int CNT_W     = 16;
  localparam int FSW       = $clog2(HAZ_DEPTH+1);

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      id_valid = 1'b0;
  logic [NUM_SRC*REG_AW-1:0] id_rs = '0;
  logic [NUM_SRC-1:0]        id_rs_used = '0;
  logic [REG_AW-1:0]         id_rd = '0;
  logic                      id_we = 1'b0;
  logic                      id_is_load = 1'b0;
  logic                      br_flush = 1'b0;

  logic                      stall_pc, stall_if_id, bubble_id_exe, flush_if_id;
  logic [NUM_SRC*FSW-1:0]    fwd_sel;
  logic [CNT_W-1:0]          stall_cnt, flush_cnt;

  logic                      s4_pc, s4_if_id, s4_bubble, s4_flush;
  logic [NUM_SRC*FSW-1:0]    s4_fwd;
  logic [3:0]                s4_stall_cnt, s4_flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .HAZ_DEPTH(HAZ_DEPTH), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .br_flush(br_flush), .stall_pc(stall_pc),
    .stall_if_id(stall_if_id), .bubble_id_exe(bubble_id_exe),
    .flush_if_id(flush_if_id), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(
    .NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .HAZ_DEPTH(HAZ_DEPTH), .CNT_W(4)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .br_flush(br_flush), .stall_pc(s4_pc),
    .stall_if_id(s4_if_id), .bubble_id_exe(s4_bubble),
    .flush_if_id(s4_flush), .fwd_sel(s4_fwd), .stall_cnt(s4_stall_cnt),
    .flush_cnt(s4_flush_cnt)
  );

  typedef struct {
    bit                     stall;
    bit                     flush;
    logic [NUM_SRC*FSW-1:0] fwd;
    int                     scnt;
    int                     fcnt;
    int                     scnt4;
    int                     fcnt4;
  } exp_t;

  typedef struct {
    int rd;
    bit ld;
    int cyc;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wq[$];
  int   cyc = 0;
  int   n_stall = 0;
  int   n_flush = 0;
  bit   last_stall = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  // One ID cycle: drive inputs, predict the response, queue it.
  task automatic id_cycle(input bit v, input int rs0, input int rs1,
                          input bit [1:0] used, input int rd, input bit we,
                          input bit ld, input bit fl);
    exp_t e;
    int   rs[NUM_SRC];
    int   near;
    bit   nld;
    bit   raw;
    int   stg;
    @(posedge clk); #1;
    id_valid   = v;
    id_rs      = {rs1[REG_AW-1:0], rs0[REG_AW-1:0]};
    id_rs_used = used;
    id_rd      = rd[REG_AW-1:0];
    id_we      = we;
    id_is_load = ld;
    br_flush   = fl;
    rs[0] = rs0;
    rs[1] = rs1;
    raw   = 0;
    e.fwd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      near = 0;
      nld  = 0;
      if (used[i] && rs[i] != 0) begin
        for (int j = wq.size() - 1; j >= 0; j--) begin
          stg = cyc - wq[j].cyc;
          if (stg >= 1 && stg <= HAZ_DEPTH && wq[j].rd == rs[i]) begin
            near = stg;
            nld  = wq[j].ld;
            break;
          end
        end
      end
`ifdef FORWARDING_EN
      if (near == 1 && nld) raw = 1;
      e.fwd[i*FSW +: FSW] = FSW'(near);
`else
      if (near != 0) raw = 1;
`endif
    end
    e.stall = v && raw && !fl;
    e.flush = fl;
    e.scnt  = sat(n_stall, CNT_W);
    e.fcnt  = sat(n_flush, CNT_W);
    e.scnt4 = sat(n_stall, 4);
    e.fcnt4 = sat(n_flush, 4);
    exp_q.push_back(e);
    if (e.stall) n_stall++;
    if (fl) n_flush++;
    if (v && we && rd != 0 && !e.stall && !fl)
      wq.push_back('{rd: rd, ld: ld, cyc: cyc});
    while (wq.size() > 0 && cyc - wq[0].cyc > HAZ_DEPTH) void'(wq.pop_front());
    last_stall = e.stall;
  endtask

  // Present the same instruction until it is no longer stalled.
  task automatic id_hold(input int rs0, input int rs1, input bit [1:0] used,
                         input int rd, input bit we, input bit ld);
    for (int n = 0; n < 8; n++) begin
      id_cycle(1, rs0, rs1, used, rd, we, ld, 0);
      if (!last_stall) break;
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0;
    id_we = 0; id_is_load = 0; br_flush = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall_pc"},    stall_pc, 0);
    chk({tag, "_stall_if_id"}, stall_if_id, 0);
    chk({tag, "_bubble"},      bubble_id_exe, 0);
    chk({tag, "_flush"},       flush_if_id, 0);
    chk({tag, "_fwd_sel"},     fwd_sel, 0);
    chk({tag, "_stall_cnt"},   stall_cnt, 0);
    chk({tag, "_flush_cnt"},   flush_cnt, 0);
    chk({tag, "_stall_cnt4"},  s4_stall_cnt, 0);
  endtask

  // Monitor: every live cycle's outputs against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall_pc",      stall_pc,      e.stall);
        chk("stall_if_id",   stall_if_id,   e.stall);
        chk("bubble_id_exe", bubble_id_exe, e.stall || e.flush);
        chk("flush_if_id",   flush_if_id,   e.flush);
        chk("fwd_sel",       fwd_sel,       e.fwd);
        chk("stall_cnt",     stall_cnt,     e.scnt);
        chk("flush_cnt",     flush_cnt,     e.fcnt);
        chk("stall_cnt4",    s4_stall_cnt,  e.scnt4);
        chk("flush_cnt4",    s4_flush_cnt,  e.fcnt4);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state with idle inputs.
    idle();
    #12;
    chk_zero("reset");
    rst_n = 1'b1;

    // Load-use: lw x5 ; add x6, x5, x1
    id_cycle(1, 0, 0, 2'b00, 5, 1, 1, 0);
    id_hold(5, 1, 2'b11, 6, 1, 0);

    // ALU-use: add x5 ; sub x7, x5, x5
    id_cycle(1, 1, 2, 2'b11, 5, 1, 0, 0);
    id_hold(5, 5, 2'b11, 7, 1, 0);
    id_cycle(0, 0, 0, 2'b00, 0, 0, 0, 0);
    id_cycle(0, 0, 0, 2'b00, 0, 0, 0, 0);
    id_cycle(0, 0, 0, 2'b00, 0, 0, 0, 0);

    // x0 writer then x0 reader; matching rs with the port not used.
    id_cycle(1, 0, 0, 2'b00, 0, 1, 1, 0);
    id_cycle(1, 0, 0, 2'b11, 8, 1, 0, 0);
    id_cycle(1, 0, 0, 2'b00, 9, 1, 1, 0);
    id_cycle(1, 9, 9, 2'b00, 10, 1, 0, 0);

    // Branch flush during a load-use stall; the squashed writer of x12
    // must not create a hazard for the following reader.
    id_cycle(1, 0, 0, 2'b00, 5, 1, 1, 0);
    id_cycle(1, 5, 0, 2'b01, 12, 1, 0, 0);
    id_cycle(1, 5, 0, 2'b01, 12, 1, 0, 1);
    id_cycle(1, 12, 12, 2'b11, 13, 1, 0, 0);

    // Back-to-back load-use pairs to push the 4-bit counters to saturation.
    for (int n = 0; n < 20; n++) begin
      id_cycle(1, 0, 0, 2'b00, 3, 1, 1, 0);
      id_hold(0, 3, 2'b10, 4, 1, 0);
    end

    // Reset asserted in the middle of a stall.
    id_cycle(1, 0, 0, 2'b00, 5, 1, 1, 0);
    id_cycle(1, 5, 0, 2'b01, 6, 1, 0, 0);
    #1;
    chk("pre_reset_stall", stall_pc, last_stall);
    rst_n = 1'b0;
    exp_q.delete();
    wq.delete();
    n_stall = 0;
    n_flush = 0;
    #1;
    chk_zero("mid_reset");
    idle();
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 2000; n++) begin
      id_cycle($urandom_range(0, 99) < 85,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)),
               $urandom_range(0, 99) < 70,
               $urandom_range(0, 99) < 40,
               $urandom_range(0, 99) < 8);
    end

    @(posedge clk); #1;
    idle();
    @(negedge clk); @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
